word_distributor: RTL
=====================

# word_distributor

Streaming word fork that sits upstream of `Word_OR_Reducer` and performs its inverse. It accepts one word per cycle with a destination mask and presents that word on every addressed slot of a WORD_COUNT-slot output bus, each with its own valid/ready handshake. Unaddressed or idle slots carry all-zero data, so OR-reducing the output bus always yields the word currently being distributed. A word retires only after every addressed consumer has accepted it.

## Interface
- WORD_WIDTH, 36, bits per word
- WORD_COUNT, 16, number of output slots; must be ≥ 2
- clock  input  1  single clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream word present
- in_ready  output  1  block can accept a word this cycle
- in_data  input  WORD_WIDTH  word to distribute
- in_mask  input  WORD_COUNT  destination slots; bit k addresses slot k
- out_valid  output  WORD_COUNT  per-slot word present
- out_ready  input  WORD_COUNT  per-slot consumer accept
- out_data  output  WORD_WIDTH*WORD_COUNT  slot k at bits [k*WORD_WIDTH +: WORD_WIDTH]
- busy  output  1  any word buffered or pending
- drop_count  output  16  zero-mask words discarded; saturates at 16'hFFFF

## Operation
- Input stage: 2-entry skid FIFO of {in_data, in_mask}. in_ready is registered and equals "FIFO not full". An input transfer occurs when in_valid && in_ready.
- Output stage: one holding register {hold_data, pending[WORD_COUNT-1:0]}. The stage is free when pending == 0.
- out_valid[k] = pending[k]. out_data slot k = hold_data when pending[k], else zero. Slot k completes when out_valid[k] && out_ready[k], which clears pending[k].
- Load: when the stage is free, or becomes free this cycle because every remaining pending bit completes, the FIFO head moves into the holding register and its mask becomes pending. Back-to-back words therefore incur no bubble.
- Zero-mask word at the FIFO head: it is popped without loading, drop_count increments, and the holding register is untouched. At most one pop per cycle.
- Slots complete independently. A slot that has accepted waits, with valid low and data zero, while the other addressed slots finish.
- out_ready is ignored on slots that are not pending.
- busy = FIFO non-empty || pending != 0.
- Reset (reset_n low, at any time including mid-transfer): FIFO emptied, pending=0, hold_data=0, drop_count=0, in_ready=0, out_valid=0, out_data=0, busy=0. A partially delivered word is lost.

## Timing
- Reset values: all outputs are 0.
- in_ready rises on the first rising edge after reset_n deasserts.
- Latency: a word accepted at edge t, with the FIFO empty and the stage free, shows out_valid at edge t+1. This is one register stage.
- Throughput: one word per cycle when every addressed slot is ready. in_ready never depends combinationally on out_ready.
- FIFO full (2 entries) forces in_ready low on the following cycle. A pop and a push in the same cycle keep occupancy constant.
- A word's data is stable on every slot for as long as that slot is pending.

## Test plan
- Single fork, WORD_WIDTH=36, WORD_COUNT=4, all out_ready=1: send 36'h123456789 with mask 4'b0101 → at t+1, out_valid=4'b0101, slots 0 and 2 = 36'h123456789, slots 1 and 3 = 0, OR of all slots = 36'h123456789; out_valid=0 at t+2.
- Staggered accept: mask 4'b1111, out_ready pattern of slot0 at t+1, slot3 at t+2, slots 1 and 2 at t+4 → pending goes 1110, 0110, 0110, 0000; the next word appears at t+5 with no bubble.
- Backpressure: hold out_ready=0 and push 3 words → in_ready low after 2 are buffered plus 1 held; release out_ready → all 3 words delivered in order, one per cycle.
- Zero mask: push mask 0 between two valid words → drop_count=1, no out_valid pulse for the dropped word, and the valid words are delivered in order.
- Reset mid-operation: drop reset_n while pending=4'b0011 and the FIFO holds 2 words → all outputs are 0 immediately; after release no stale word appears and the first new word is delivered normally.
- Saturation: force 65536 zero-mask words → drop_count stays at 16'hFFFF.

Source files
------------

// File: rtl/word_distributor_if.sv
// Bundle of the upstream handshake, the per-slot output bus and the status
// outputs of word_distributor. The block itself connects through "slave";
// the driving environment uses "master".
interface word_distributor_if #(
    parameter int WORD_WIDTH = 36,
    parameter int WORD_COUNT = 16
);
    logic                             in_valid;
    logic                             in_ready;
    logic [WORD_WIDTH-1:0]            in_data;
    logic [WORD_COUNT-1:0]            in_mask;
    logic [WORD_COUNT-1:0]            out_valid;
    logic [WORD_COUNT-1:0]            out_ready;
    logic [WORD_WIDTH*WORD_COUNT-1:0] out_data;
    logic                             busy;
    logic [15:0]                      drop_count;

    modport slave (
        input  in_valid, in_data, in_mask, out_ready,
        output in_ready, out_valid, out_data, busy, drop_count
    );

    modport master (
        output in_valid, in_data, in_mask, out_ready,
        input  in_ready, out_valid, out_data, busy, drop_count
    );
endinterface

// File: rtl/word_distributor.sv
// Streaming word fork: each accepted word is presented on every slot named
// by its mask, with an independent valid/ready per slot. Unaddressed slots
// carry zero, so OR-reducing the bus always yields the word being delivered.
// A 2-entry skid FIFO decouples in_ready from the downstream readies.
module word_distributor #(
    parameter int WORD_WIDTH = 36,
    parameter int WORD_COUNT = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    word_distributor_if.slave   bus
);

    // Skid FIFO storage and control
    logic [WORD_WIDTH-1:0] fifo_data [2];
    logic [WORD_COUNT-1:0] fifo_mask [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic [1:0]            count_nxt;
    logic                  in_ready_q;

    // Holding stage
    logic [WORD_WIDTH-1:0] hold_data;
    logic [WORD_COUNT-1:0] pending;
    logic [WORD_COUNT-1:0] remaining;
    logic [15:0]           drop_count_q;

    logic                  push;
    logic                  pop;
    logic                  load;
    logic                  drop;
    logic                  head_zero;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Transfer decisions: a pop either loads the head or discards a zero-mask head
    always_comb begin
        push      = bus.in_valid && in_ready_q;
        remaining = pending & ~bus.out_ready;
        head_zero = (fifo_mask[rd_ptr] == '0);
        pop       = (count != 2'd0) && (head_zero || (remaining == '0));
        load      = pop && !head_zero;
        drop      = pop && head_zero;
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 2'd1;
        end else if (pop && !push) begin
            count_nxt = count - 2'd1;
        end
    end

    // FIFO payload; unread entries are masked by count so they need no reset
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_data[wr_ptr] <= bus.in_data;
            fifo_mask[wr_ptr] <= bus.in_mask;
        end
    end

    // FIFO pointers, occupancy and the registered not-full ready
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            in_ready_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count      <= count_nxt;
            in_ready_q <= (count_nxt != 2'd2);
        end
    end

    // Holding stage: reload as soon as the last pending slot completes (no bubble)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending      <= '0;
            hold_data    <= '0;
            drop_count_q <= 16'd0;
        end else begin
            if (load) begin
                pending   <= fifo_mask[rd_ptr];
                hold_data <= fifo_data[rd_ptr];
            end else begin
                pending   <= remaining;
            end
            if (drop) begin
                drop_count_q <= sat_inc16(drop_count_q);
            end
        end
    end

    // Per-slot presentation: data only where the slot is still pending
    always_comb begin
        bus.out_data = '0;
        for (int k = 0; k < WORD_COUNT; k++) begin
            if (pending[k]) begin
                bus.out_data[k*WORD_WIDTH +: WORD_WIDTH] = hold_data;
            end
        end
    end

    assign bus.out_valid  = pending;
    assign bus.in_ready   = in_ready_q;
    assign bus.busy       = (count != 2'd0) || (pending != '0);
    assign bus.drop_count = drop_count_q;

endmodule
